// File: rtl/read_bpm_test_link.sv
// read_bpm_test_link: receive-side checker for the synthetic BPM test link.
// Checks every word of the per-FA-cycle packet ({header, X, Y, S} per BPM)
// against the deterministic pattern and issues one verdict per FA session.
// Optional build macro BPM_TEST_FA_SEQ_CHECK_EN: when defined, each good
// packet's FA cycle number F must be the previous good F + 1 (mod 2^16).
//
// state | meaning
// IDLE  | waiting for auroraFAstrobe, beats ignored
// HDR   | expecting header word of BPM bpm_idx
// X     | expecting X word of BPM bpm_idx
// Y     | expecting Y word of BPM bpm_idx
// S     | expecting S word of BPM bpm_idx (F latched at bpm_idx 0)
// DRAIN | framing error reported, discarding beats until tlast
module read_bpm_test_link #(
    parameter int BPM_COUNT        = 16,
    parameter int CELL_INDEX       = 12,
    parameter int BPM_GLOBAL_INDEX = 2,
    parameter int FOFB_INDEX_WIDTH = 9
) (
    input  logic        auroraUserClk,
    input  logic        auroraUserReset_n,
    input  logic        auroraFAstrobe,
    input  logic [31:0] BPM_TEST_AXI_STREAM_RX_tdata,
    input  logic        BPM_TEST_AXI_STREAM_RX_tvalid,
    input  logic        BPM_TEST_AXI_STREAM_RX_tlast,
    output logic        BPM_TEST_AXI_STREAM_RX_tready,
    output logic        TESTstatusStrobe,
    output logic [1:0]  TESTstatusCode,
    output logic [15:0] TESTgoodCount,
    output logic [15:0] TESTbadCount,
    output logic [15:0] TESTlastFAcycle
);

    // FOFB index field = {global index prefix, 5-bit BPM index}
    localparam int                GIDX_W   = FOFB_INDEX_WIDTH - 5;
    localparam logic [GIDX_W-1:0] GIDX     = GIDX_W'(BPM_GLOBAL_INDEX);
    localparam logic [4:0]        CELL5    = 5'(CELL_INDEX);
    localparam logic [4:0]        LAST_IDX = 5'(BPM_COUNT - 1);

    localparam logic [1:0] CODE_GOOD     = 2'd0;
    localparam logic [1:0] CODE_MISMATCH = 2'd1;
    localparam logic [1:0] CODE_FRAMING  = 2'd2;
    localparam logic [1:0] CODE_MISSING  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_X,
        ST_Y,
        ST_S,
        ST_DRAIN
    } state_t;

    state_t      state;
    logic [4:0]  bpm_idx;
    logic        mismatch_seen;
    logic [15:0] fa_cycle;
    logic        verdict_done;
    logic        started;

    logic        accept;
    logic        parsing;
    logic        final_beat;
    logic [15:0] f_now;
    logic [31:0] exp_word;
    logic        word_bad;
    logic        seq_bad;
    logic        issue;
    logic [1:0]  issue_code;

    assign accept     = BPM_TEST_AXI_STREAM_RX_tvalid & BPM_TEST_AXI_STREAM_RX_tready;
    assign parsing    = (state == ST_HDR) || (state == ST_X) || (state == ST_Y) || (state == ST_S);
    assign final_beat = (state == ST_S) && (bpm_idx == LAST_IDX);
    assign word_bad   = (BPM_TEST_AXI_STREAM_RX_tdata != exp_word);

    // Expected word for the current position; F comes from this beat when bpm_idx is 0
    always_comb begin
        f_now    = (bpm_idx == 5'd0) ? BPM_TEST_AXI_STREAM_RX_tdata[31:16] : fa_cycle;
        exp_word = BPM_TEST_AXI_STREAM_RX_tdata;
        case (state)
            ST_HDR:  exp_word = {16'hA5BE, 1'b1, CELL5, 1'b0, GIDX, bpm_idx};
            ST_X:    exp_word = {16'hCAFE, 11'b0, bpm_idx};
            ST_Y:    exp_word = {16'hBEEF, 11'b0, bpm_idx};
            ST_S:    exp_word = {f_now, 11'b0, bpm_idx};
            default: exp_word = BPM_TEST_AXI_STREAM_RX_tdata;
        endcase
    end

`ifdef BPM_TEST_FA_SEQ_CHECK_EN
    logic have_prev_good;
    // F must follow the last good packet's F; the first packet after reset has no predecessor
    assign seq_bad = have_prev_good && (f_now != 16'(TESTlastFAcycle + 16'd1));
`else
    assign seq_bad = 1'b0;
`endif

    // Verdict decode: a strobe that finds the session unanswered wins over any beat
    always_comb begin
        issue      = 1'b0;
        issue_code = CODE_GOOD;
        if (auroraFAstrobe) begin
            if (started && !verdict_done) begin
                issue      = 1'b1;
                issue_code = CODE_MISSING;
            end
        end else if (accept && parsing) begin
            if (final_beat && BPM_TEST_AXI_STREAM_RX_tlast) begin
                issue      = 1'b1;
                issue_code = (mismatch_seen || word_bad || seq_bad) ? CODE_MISMATCH : CODE_GOOD;
            end else if (final_beat || BPM_TEST_AXI_STREAM_RX_tlast) begin
                issue      = 1'b1;
                issue_code = CODE_FRAMING;
            end
        end
    end

    // Packet parser FSM with registered status outputs and counters
    always_ff @(posedge auroraUserClk or negedge auroraUserReset_n) begin
        if (!auroraUserReset_n) begin
            state                         <= ST_IDLE;
            bpm_idx                       <= 5'd0;
            mismatch_seen                 <= 1'b0;
            fa_cycle                      <= 16'd0;
            verdict_done                  <= 1'b0;
            started                       <= 1'b0;
            BPM_TEST_AXI_STREAM_RX_tready <= 1'b0;
            TESTstatusStrobe              <= 1'b0;
            TESTstatusCode                <= 2'd0;
            TESTgoodCount                 <= 16'd0;
            TESTbadCount                  <= 16'd0;
            TESTlastFAcycle               <= 16'd0;
`ifdef BPM_TEST_FA_SEQ_CHECK_EN
            have_prev_good                <= 1'b0;
`endif
        end else begin
            BPM_TEST_AXI_STREAM_RX_tready <= 1'b1;
            TESTstatusStrobe              <= issue;
            if (issue) begin
                TESTstatusCode <= issue_code;
                verdict_done   <= 1'b1;
                if (issue_code == CODE_GOOD) begin
                    TESTgoodCount   <= TESTgoodCount + 16'd1;
                    TESTlastFAcycle <= f_now;
`ifdef BPM_TEST_FA_SEQ_CHECK_EN
                    have_prev_good  <= 1'b1;
`endif
                end else begin
                    TESTbadCount <= TESTbadCount + 16'd1;
                end
            end

            if (auroraFAstrobe) begin
                // New session: any beat in this cycle is dropped
                state         <= ST_HDR;
                bpm_idx       <= 5'd0;
                mismatch_seen <= 1'b0;
                verdict_done  <= 1'b0;
                started       <= 1'b1;
            end else if (accept) begin
                case (state)
                    ST_IDLE: begin
                    end
                    ST_DRAIN: begin
                        if (BPM_TEST_AXI_STREAM_RX_tlast)
                            state <= ST_IDLE;
                    end
                    ST_HDR, ST_X, ST_Y, ST_S: begin
                        if (word_bad)
                            mismatch_seen <= 1'b1;
                        if ((state == ST_S) && (bpm_idx == 5'd0))
                            fa_cycle <= BPM_TEST_AXI_STREAM_RX_tdata[31:16];
                        if (final_beat)
                            state <= BPM_TEST_AXI_STREAM_RX_tlast ? ST_IDLE : ST_DRAIN;
                        else if (BPM_TEST_AXI_STREAM_RX_tlast)
                            state <= ST_IDLE;
                        else begin
                            case (state)
                                ST_HDR:  state <= ST_X;
                                ST_X:    state <= ST_Y;
                                ST_Y:    state <= ST_S;
                                default: begin
                                    state   <= ST_HDR;
                                    bpm_idx <= bpm_idx + 5'd1;
                                end
                            endcase
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_read_bpm_test_link.sv
// Testbench for read_bpm_test_link: directed sessions with randomized gaps
// and corruption, checked against a packet-level reference model.
`timescale 1ns/1ps
module tb_read_bpm_test_link;

    localparam int BPM = 16;
    localparam int NW  = 4 * BPM;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fa = 1'b0;
    logic [31:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        tready;
    logic        sstrobe;
    logic [1:0]  scode;
    logic [15:0] gcnt, bcnt, lastfa;

    read_bpm_test_link dut (
        .auroraUserClk                (clk),
        .auroraUserReset_n            (rst_n),
        .auroraFAstrobe               (fa),
        .BPM_TEST_AXI_STREAM_RX_tdata (tdata),
        .BPM_TEST_AXI_STREAM_RX_tvalid(tvalid),
        .BPM_TEST_AXI_STREAM_RX_tlast (tlast),
        .BPM_TEST_AXI_STREAM_RX_tready(tready),
        .TESTstatusStrobe             (sstrobe),
        .TESTstatusCode               (scode),
        .TESTgoodCount                (gcnt),
        .TESTbadCount                 (bcnt),
        .TESTlastFAcycle              (lastfa)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int strobe_seen = 0;
    int ready_low = 0;

    // reference model state
    logic [15:0] m_good = 0, m_bad = 0, m_last = 0;
    bit          m_prev_ok = 0;
    int          m_strobes = 0;

    logic [31:0] pkt_data [NW];
    bit          pkt_last [NW];
    int          pkt_len;

    always @(negedge clk) if (sstrobe === 1'b1) strobe_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] gold(input int p, input logic [15:0] f);
        logic [4:0] i = 5'(p / 4);
        case (p % 4)
            0:       return {16'hA5BE, 1'b1, 5'd12, 1'b0, 4'd2, i};
            1:       return {16'hCAFE, 11'h0, i};
            2:       return {16'hBEEF, 11'h0, i};
            default: return {f, 11'h0, i};
        endcase
    endfunction

    function automatic void make_good(input logic [15:0] f);
        for (int p = 0; p < NW; p++) begin
            pkt_data[p] = gold(p, f);
            pkt_last[p] = (p == NW - 1);
        end
        pkt_len = NW;
    endfunction

    // Framing first, then content against the pattern with F from the first S word
    function automatic int model_code();
        logic [15:0] f;
        bit bad = 0;
        for (int p = 0; p < pkt_len; p++) begin
            if (pkt_last[p] && p != NW - 1) return 2;
            if (p == NW - 1 && !pkt_last[p]) return 2;
        end
        f = pkt_data[3][31:16];
        for (int p = 0; p < pkt_len; p++)
            if (pkt_data[p] !== gold(p, f)) bad = 1;
        return bad ? 1 : 0;
    endfunction

    task automatic model_apply(input int code_in, output int code_out);
        code_out = code_in;
`ifdef BPM_TEST_FA_SEQ_CHECK_EN
        if (code_out == 0 && m_prev_ok && pkt_data[3][31:16] != 16'(m_last + 16'd1))
            code_out = 1;
`endif
        if (code_out == 0) begin
            m_good++;
            m_last = pkt_data[3][31:16];
            m_prev_ok = 1;
        end else begin
            m_bad++;
        end
        m_strobes++;
    endtask

    task automatic send(input int start, input int len, input int gap_pct);
        for (int p = start; p < start + len; p++) begin
            for (int g = 0; g < 8 && $urandom_range(99) < gap_pct; g++) begin
                tvalid = 1'b0;
                tdata  = $urandom;
                @(negedge clk);
                if (tready !== 1'b1) ready_low++;
            end
            tvalid = 1'b1;
            tdata  = pkt_data[p];
            tlast  = pkt_last[p];
            @(negedge clk);
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic fa_pulse();
        fa = 1'b1;
        @(negedge clk);
        fa = 1'b0;
    endtask

    // Called at the negedge right after the deciding edge
    task automatic chk_verdict(input string tag, input int code_in);
        int code;
        model_apply(code_in, code);
        chk({tag, "_strobe"}, 32'(sstrobe), 32'd1);
        chk({tag, "_code"}, 32'(scode), 32'(code));
        chk({tag, "_good"}, 32'(gcnt), 32'(m_good));
        chk({tag, "_bad"}, 32'(bcnt), 32'(m_bad));
        chk({tag, "_lastfa"}, 32'(lastfa), 32'(m_last));
        @(negedge clk);
        chk({tag, "_strobe_fall"}, 32'(sstrobe), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tready"}, 32'(tready), 32'd0);
        chk({tag, "_strobe"}, 32'(sstrobe), 32'd0);
        chk({tag, "_code"}, 32'(scode), 32'd0);
        chk({tag, "_good"}, 32'(gcnt), 32'd0);
        chk({tag, "_bad"}, 32'(bcnt), 32'd0);
        chk({tag, "_lastfa"}, 32'(lastfa), 32'd0);
    endtask

    task automatic chk_strobe_total(input string tag);
        #2;
        chk(tag, 32'(strobe_seen), 32'(m_strobes));
    endtask

    initial begin
        int pos;
        // reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("tready_up", 32'(tready), 32'd1);

        // first strobe after reset is exempt; good packet F=1
        fa_pulse();
        chk("first_fa_no_strobe", 32'(sstrobe), 32'd0);
        make_good(16'd1);
        send(0, NW, 0);
        chk_verdict("good1", model_code());

        // X of BPM 5 corrupted
        fa_pulse();
        chk("fa_after_verdict", 32'(sstrobe), 32'd0);
        make_good(16'(m_last + 16'd1));
        pkt_data[21] = 32'hCAFE0006;
        send(0, NW, 0);
        chk_verdict("x5_bad", model_code());

        // early tlast on Y of BPM 3, rest of packet ignored
        fa_pulse();
        make_good(16'(m_last + 16'd1));
        pkt_last[14] = 1'b1;
        pkt_len = 15;
        send(0, 15, 0);
        chk_verdict("early_tlast", model_code());
        pkt_last[14] = 1'b0;
        send(15, NW - 15, 0);
        repeat (2) @(negedge clk);
        chk_strobe_total("ignored_after_tlast");

        // two strobes with nothing between them
        fa_pulse();
        chk("fa_idle_seen", 32'(sstrobe), 32'd0);
        fa_pulse();
        chk_verdict("missing", 3);
        make_good(16'(m_last + 16'd1));
        send(0, NW, 0);
        chk_verdict("good_after_missing", model_code());

        // ~50% tvalid gaps
        fa_pulse();
        make_good(16'(m_last + 16'd1));
        send(0, NW, 50);
        chk_verdict("gaps", model_code());
        chk("tready_in_gaps", 32'(ready_low), 32'd0);

        // random single-bit corruption anywhere in the packet
        for (int k = 0; k < 3; k++) begin
            fa_pulse();
            make_good(16'(m_last + 16'd1));
            pos = $urandom_range(NW - 1);
            pkt_data[pos] = pkt_data[pos] ^ (32'd1 << $urandom_range(31));
            send(0, NW, 25);
            chk_verdict("rand_corrupt", model_code());
        end

        // final S without tlast, then drain to tlast
        fa_pulse();
        make_good(16'(m_last + 16'd1));
        pkt_last[NW - 1] = 1'b0;
        send(0, NW, 0);
        chk_verdict("no_tlast", model_code());
        tvalid = 1'b1; tdata = $urandom; tlast = 1'b0;
        repeat (2) @(negedge clk);
        tlast = 1'b1;
        @(negedge clk);
        tvalid = 1'b0; tlast = 1'b0;
        fa_pulse();
        chk("fa_after_drain", 32'(sstrobe), 32'd0);
        make_good(16'(m_last + 16'd1));
        send(0, NW, 0);
        chk_verdict("good_after_drain", model_code());

        // strobe mid-packet
        fa_pulse();
        make_good(16'(m_last + 16'd1));
        send(0, 10, 0);
        fa_pulse();
        chk_verdict("fa_mid_packet", 3);
        send(0, NW, 0);
        chk_verdict("good_after_restart", model_code());

        // reset mid-packet
        fa_pulse();
        make_good(16'(m_last + 16'd1));
        send(0, 20, 0);
        tvalid = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("mid_reset");
        tvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_good = 0; m_bad = 0; m_last = 0; m_prev_ok = 0;
        @(negedge clk);
        chk_strobe_total("no_strobe_on_reset");

        // FA sequence: F = 1, 2, 4
        fa_pulse();
        chk("fa_after_reset_exempt", 32'(sstrobe), 32'd0);
        make_good(16'd1);
        send(0, NW, 0);
        chk_verdict("seq_f1", model_code());
        fa_pulse();
        make_good(16'd2);
        send(0, NW, 0);
        chk_verdict("seq_f2", model_code());
        fa_pulse();
        make_good(16'd4);
        send(0, NW, 0);
        chk_verdict("seq_f4", model_code());

        repeat (3) @(negedge clk);
        chk_strobe_total("strobe_total");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
